alarm_timer_unit: RTL and testbench
===================================

ALARM_TIMER_UNIT -- requirements
Module: alarm_timer_unit

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning reference clock cycles per second.
REQ-002 The block SHALL have parameter P2_SECONDS, default 5, meaning the short-delay (arming) duration in seconds.
REQ-003 The block SHALL have parameter P1_SECONDS, default 10, meaning the long-delay (re-arm) duration in seconds.
REQ-004 The block SHALL have port CLOCK_IN  input  1  reference clock; all logic on the rising edge.
REQ-005 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port ENABLE_COUNT_P2  input  1  level request to run the P2 delay.
REQ-007 The block SHALL have port ENABLE_COUNT_P1  input  1  level request to run the P1 delay.
REQ-008 The block SHALL have port CLOCK_1  output  1  free-running 1 Hz square wave for strobe blinking.
REQ-009 The block SHALL have port COUNT_OUT_P2  output  1  P2 delay complete, level.
REQ-010 The block SHALL have port COUNT_OUT_P1  output  1  P1 delay complete, level.
REQ-011 The block SHALL have port SECONDS_LEFT  output  4  whole seconds remaining on the active delay, for display.

Function
REQ-012 Design rules SHALL hold: one clock, reset asynchronous and active-low; all outputs registered; P1_SECONDS and P2_SECONDS SHALL be in 1..15; CLK_HZ SHALL be even and >= 2.
REQ-013 Prescaler: a free-running counter SHALL count 0..CLK_HZ-1 and wrap to 0; it is unaffected by the enables.
REQ-014 CLOCK_1 SHALL be 0 while prescaler < CLK_HZ/2 and 1 otherwise (50% duty, period exactly CLK_HZ cycles).
REQ-015 Each delay channel (P2, P1) SHALL be an independent FSM with states IDLE, RUN, DONE, its own sub-second counter (0..CLK_HZ-1) and its own seconds counter.
REQ-016 IDLE: counters held at 0, COUNT_OUT low; enable sampled high -> RUN on that edge, counting starts from 0 (not aligned to the prescaler).
REQ-017 RUN: sub-second counter increments each cycle, wraps at CLK_HZ-1 and increments the seconds counter on the wrap.
REQ-018 RUN -> DONE SHALL occur on the edge at which enable has been sampled high for exactly N*CLK_HZ consecutive cycles (N = channel seconds); COUNT_OUT goes high on that same edge.
REQ-019 DONE: COUNT_OUT SHALL stay high while enable stays high; counters frozen.
REQ-020 Enable sampled low in RUN or DONE SHALL return the channel to IDLE on that edge: counters cleared, COUNT_OUT low; no partial progress is retained.
REQ-021 Re-asserting enable after any deassertion SHALL restart a full N-second delay.
REQ-022 Both enables high together SHALL run both channels independently with no interaction.
REQ-023 SECONDS_LEFT SHALL be N1 minus P1 elapsed seconds if P1 is in RUN; else N2 minus P2 elapsed seconds if P2 is in RUN; else 0. P1 has display priority.
REQ-024 SECONDS_LEFT SHALL read N on the first RUN cycle and never reach 0 while in RUN (minimum 1).

Reset
REQ-025 RESET_N low SHALL immediately force: prescaler 0, CLOCK_1 0, both channels IDLE with counters 0, COUNT_OUT_P2 0, COUNT_OUT_P1 0, SECONDS_LEFT 0.
REQ-026 Reset asserted mid-delay SHALL abort it; after release with enable still high, the channel SHALL start a full delay from the first sampled-high edge.

Verification (CLK_HZ=10, P2_SECONDS=5, P1_SECONDS=10)
REQ-027 Free run after reset release -> CLOCK_1 low 5 cycles, high 5 cycles, repeating; period 10 cycles.
REQ-028 ENABLE_COUNT_P2 high and held -> COUNT_OUT_P2 rises on the 50th sampled-high edge, stays high; SECONDS_LEFT steps 5,4,3,2,1 every 10 cycles, then 0.
REQ-029 ENABLE_COUNT_P1 high for 37 cycles, low 1 cycle, high again -> no COUNT_OUT_P1 after the first burst; rises 100 edges after re-assertion.
REQ-030 Both enables raised on the same edge -> COUNT_OUT_P2 at edge 50, COUNT_OUT_P1 at edge 100; SECONDS_LEFT shows P1 values (10..1) throughout.
REQ-031 COUNT_OUT_P2 high then ENABLE_COUNT_P2 dropped -> COUNT_OUT_P2 low on the next edge, SECONDS_LEFT 0.
REQ-032 RESET_N pulsed low at cycle 30 of a P2 delay with enable held -> all outputs 0 asynchronously; COUNT_OUT_P2 rises 50 edges after release.

Source files
------------

// File: rtl/alarm_timer_unit.sv
// Alarm timing: free-running 1 Hz strobe plus two independent enable-held delays (P2 arm, P1 re-arm).
// Latency: all outputs registered, one edge after the sampled inputs; no backpressure.

module alarm_delay_channel #(
  parameter int CLK_HZ  = 50000000,
  parameter int SECONDS = 5
) (
  input  logic       CLOCK_IN,
  input  logic       RESET_N,
  input  logic       enable,
  output logic       count_out,
  output logic       run_nxt,
  output logic [3:0] sec_nxt
);
  localparam int SUB_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [SUB_W-1:0] SUB_WRAP  = SUB_W'(CLK_HZ - 1);
  localparam logic [SUB_W-1:0] SUB_FINAL = SUB_W'(CLK_HZ - 2);
  localparam logic [3:0]       SEC_FINAL = 4'(SECONDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [SUB_W-1:0] sub_cnt, sub_nxt;
  logic [3:0]       sec_cnt;

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      sub_cnt   <= '0;
      sec_cnt   <= '0;
      count_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      sub_cnt   <= sub_nxt;
      sec_cnt   <= sec_nxt;
      count_out <= (state_nxt == DONE);
    end
  end

  // Completion is detected one count early so DONE lands on exactly the N*CLK_HZ-th high edge.
  always_comb begin
    state_nxt = state;
    sub_nxt   = sub_cnt;
    sec_nxt   = sec_cnt;
    case (state)
      IDLE: begin
        sub_nxt = '0;
        sec_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
          sub_nxt   = '0;
          sec_nxt   = '0;
        end else if (sec_cnt == SEC_FINAL && sub_cnt == SUB_FINAL) begin
          state_nxt = DONE;
          sub_nxt   = SUB_WRAP;
        end else if (sub_cnt == SUB_WRAP) begin
          sub_nxt = '0;
          sec_nxt = sec_cnt + 4'd1;
        end else begin
          sub_nxt = sub_cnt + 1'b1;
        end
      end
      DONE: begin
        if (!enable) begin
          state_nxt = IDLE;
          sub_nxt   = '0;
          sec_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        sub_nxt   = '0;
        sec_nxt   = '0;
      end
    endcase
  end

  assign run_nxt = (state_nxt == RUN);
endmodule

module alarm_timer_unit #(
  parameter int CLK_HZ     = 50000000,
  parameter int P2_SECONDS = 5,
  parameter int P1_SECONDS = 10
) (
  input  logic       CLOCK_IN,
  input  logic       RESET_N,
  input  logic       ENABLE_COUNT_P2,
  input  logic       ENABLE_COUNT_P1,
  output logic       CLOCK_1,
  output logic       COUNT_OUT_P2,
  output logic       COUNT_OUT_P1,
  output logic [3:0] SECONDS_LEFT
);
  localparam int PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_WRAP = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

  logic [PRE_W-1:0] prescale, prescale_nxt;
  logic             p2_run_nxt, p1_run_nxt;
  logic [3:0]       p2_sec_nxt, p1_sec_nxt;
  logic [3:0]       seconds_left_nxt;

  alarm_delay_channel #(.CLK_HZ(CLK_HZ), .SECONDS(P2_SECONDS)) u_p2 (
    .CLOCK_IN  (CLOCK_IN),
    .RESET_N   (RESET_N),
    .enable    (ENABLE_COUNT_P2),
    .count_out (COUNT_OUT_P2),
    .run_nxt   (p2_run_nxt),
    .sec_nxt   (p2_sec_nxt)
  );

  alarm_delay_channel #(.CLK_HZ(CLK_HZ), .SECONDS(P1_SECONDS)) u_p1 (
    .CLOCK_IN  (CLOCK_IN),
    .RESET_N   (RESET_N),
    .enable    (ENABLE_COUNT_P1),
    .count_out (COUNT_OUT_P1),
    .run_nxt   (p1_run_nxt),
    .sec_nxt   (p1_sec_nxt)
  );

  // Display follows the next channel state so it stays aligned with the registered COUNT_OUTs.
  always_comb begin
    prescale_nxt     = (prescale == PRE_WRAP) ? '0 : prescale + 1'b1;
    seconds_left_nxt = 4'd0;
    if (p1_run_nxt)      seconds_left_nxt = 4'(P1_SECONDS) - p1_sec_nxt;
    else if (p2_run_nxt) seconds_left_nxt = 4'(P2_SECONDS) - p2_sec_nxt;
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      prescale     <= '0;
      CLOCK_1      <= 1'b0;
      SECONDS_LEFT <= 4'd0;
    end else begin
      prescale     <= prescale_nxt;
      CLOCK_1      <= (prescale_nxt >= PRE_HALF);
      SECONDS_LEFT <= seconds_left_nxt;
    end
  end
endmodule

// File: tb/tb_alarm_timer_unit.sv
// Bench for alarm_timer_unit at CLK_HZ=10, P2=5 s, P1=10 s: vector table, corner sequences, random enables vs. model.
module tb_alarm_timer_unit;
  localparam int C  = 10;
  localparam int N2 = 5;
  localparam int N1 = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en2 = 1'b0;
  logic       en1 = 1'b0;
  logic       clock_1, out_p2, out_p1;
  logic [3:0] seconds_left;

  alarm_timer_unit #(.CLK_HZ(C), .P2_SECONDS(N2), .P1_SECONDS(N1)) dut (
    .CLOCK_IN        (clk),
    .RESET_N         (rst_n),
    .ENABLE_COUNT_P2 (en2),
    .ENABLE_COUNT_P1 (en1),
    .CLOCK_1         (clock_1),
    .COUNT_OUT_P2    (out_p2),
    .COUNT_OUT_P1    (out_p1),
    .SECONDS_LEFT    (seconds_left)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: edges since reset and consecutive sampled-high edges per channel.
  int ticks = 0;
  int cnt2  = 0;
  int cnt1  = 0;

  typedef struct {
    int cycles;
    bit e2;
    bit e1;
    bit x2;
    bit x1;
    int xsl;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_left();
    if (cnt1 >= 1 && cnt1 < N1 * C) return N1 - (cnt1 - 1) / C;
    if (cnt2 >= 1 && cnt2 < N2 * C) return N2 - (cnt2 - 1) / C;
    return 0;
  endfunction

  task automatic model_check();
    chk("clock_1", int'(clock_1), int'((ticks % C) >= C / 2));
    chk("count_out_p2", int'(out_p2), int'(cnt2 >= N2 * C));
    chk("count_out_p1", int'(out_p1), int'(cnt1 >= N1 * C));
    chk("seconds_left", int'(seconds_left), m_left());
  endtask

  // Called from a falling edge: drive, take one rising edge, compare on the next falling edge.
  task automatic step(input bit e2, input bit e1);
    en2 = e2;
    en1 = e1;
    @(posedge clk);
    ticks++;
    cnt2 = e2 ? cnt2 + 1 : 0;
    cnt1 = e1 ? cnt1 + 1 : 0;
    @(negedge clk);
    model_check();
  endtask

  task automatic all_zero(input string name);
    chk({name, "_clock_1"}, int'(clock_1), 0);
    chk({name, "_p2"}, int'(out_p2), 0);
    chk({name, "_p1"}, int'(out_p1), 0);
    chk({name, "_left"}, int'(seconds_left), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    cnt2  = 0;
    cnt1  = 0;
  endtask

  initial begin
    tbl[0]  = '{49, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{5,  1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[3]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{37, 1'b0, 1'b1, 1'b0, 1'b0, 7};
    tbl[5]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{99, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{1,  1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[8]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 10};
    tbl[10] = '{49, 1'b1, 1'b1, 1'b1, 1'b0, 6};
    tbl[11] = '{50, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[12] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[13] = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[14] = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 10};
    tbl[15] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 4};
    tbl[16] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 0};

    // Reset held across the first rising edge, then release on a falling edge.
    @(negedge clk);
    all_zero("reset_state");
    rst_n = 1'b1;

    // Strobe: five low edges then five high edges, twice.
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      chk("strobe_phase", int'(clock_1), int'(((k % 10) >= 5)));
    end

    do_reset();
    for (int r = 0; r < 17; r++) begin
      for (int k = 0; k < tbl[r].cycles; k++) step(tbl[r].e2, tbl[r].e1);
      chk($sformatf("vec%0d_p2", r), int'(out_p2), int'(tbl[r].x2));
      chk($sformatf("vec%0d_p1", r), int'(out_p1), int'(tbl[r].x1));
      chk($sformatf("vec%0d_left", r), int'(seconds_left), tbl[r].xsl);
    end

    // P2 display steps: first RUN cycle shows 5, one edge before completion shows 1.
    do_reset();
    step(1'b1, 1'b0);
    chk("p2_first_left", int'(seconds_left), 5);
    for (int k = 2; k <= 10; k++) step(1'b1, 1'b0);
    chk("p2_left_edge10", int'(seconds_left), 5);
    step(1'b1, 1'b0);
    chk("p2_left_edge11", int'(seconds_left), 4);

    // Reset pulse 30 cycles into a P2 delay with enable held: a full delay restarts afterwards.
    do_reset();
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0);
    do_reset();
    for (int k = 0; k < 49; k++) step(1'b1, 1'b0);
    chk("post_reset_p2_edge49", int'(out_p2), 0);
    step(1'b1, 1'b0);
    chk("post_reset_p2_edge50", int'(out_p2), 1);
    step(1'b0, 1'b0);
    chk("p2_drop_out", int'(out_p2), 0);
    chk("p2_drop_left", int'(seconds_left), 0);

    // Random enables with long holds so both channels regularly complete.
    do_reset();
    begin
      bit r2 = 1'b0;
      bit r1 = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 79) == 0) r2 = ~r2;
        if ($urandom_range(0, 139) == 0) r1 = ~r1;
        step(r2, r1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
